// File: rtl/next_pc_predictor.sv
// -----------------------------------------------------------------------------
// next_pc_predictor
//
// Fetch-stage next-PC generator. It sits directly upstream of the PC register
// and drives that register's PC_In. Each fetch is predicted from a
// direct-mapped branch target buffer (BTB) that holds a 2-bit saturating
// counter per entry. The BTB learns from branches resolved in EX. On a
// misprediction the block redirects fetch to the corrected PC and raises a
// flush for the younger stages. Two saturating counters track resolved
// branches and mispredicts.
//
// Ports
//   clk             clock; all state updates on the rising edge
//   reset           asynchronous, active-high reset
//   pc_current      current PC_Out of the PC register
//   ex_valid        EX holds a resolved conditional branch or jump
//   ex_pc           PC of the resolved branch
//   ex_taken        actual branch outcome
//   ex_target       actual taken target
//   ex_pred_taken   prediction carried down the pipe with that branch
//   ex_pred_target  predicted target carried with that branch
//   next_pc         value for PC_In
//   pred_taken      prediction for pc_current (carried to EX by the pipeline)
//   pred_target     predicted target for pc_current
//   flush           mispredict this cycle; squash younger instructions
//   branch_cnt      number of resolved branches (saturating)
//   mispredict_cnt  number of mispredicts (saturating)
// -----------------------------------------------------------------------------
module next_pc_predictor #(
  parameter int ENTRIES    = 16,
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc_current,
  input  logic        ex_valid,
  input  logic [63:0] ex_pc,
  input  logic        ex_taken,
  input  logic [63:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [63:0] ex_pred_target,
  output logic [63:0] next_pc,
  output logic        pred_taken,
  output logic [63:0] pred_target,
  output logic        flush,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispredict_cnt
);

  localparam int TAG_LO = INDEX_BITS + 2;
  localparam int TAG_HI = INDEX_BITS + TAG_BITS + 1;

  // BTB storage
  logic                valid_q  [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [63:0]         target_q [ENTRIES];

  // Lookup side
  logic [INDEX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0]   lk_tag;
  logic                  lk_hit;
  logic [63:0]           pc_plus4;

  // Update side
  logic [INDEX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0]   ex_tag;
  logic                  ex_hit;
  logic [63:0]           ex_pc_plus4;
  logic                  mispredict;

  assign lk_idx      = pc_current[INDEX_BITS+1:2];
  assign lk_tag      = pc_current[TAG_HI:TAG_LO];
  assign ex_idx      = ex_pc[INDEX_BITS+1:2];
  assign ex_tag      = ex_pc[TAG_HI:TAG_LO];
  assign pc_plus4    = pc_current + 64'd4;
  assign ex_pc_plus4 = ex_pc + 64'd4;

  // The valid bit gates the tag compare, so never-written tag/target storage
  // cannot leak onto the outputs.
  assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign ex_hit      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  assign pred_taken  = lk_hit && ctr_q[lk_idx][1];
  assign pred_target = lk_hit ? target_q[lk_idx] : pc_plus4;

  // A wrong direction, or a right "taken" with a wrong target, is a mispredict.
  assign mispredict  = ex_valid &&
                       ((ex_taken != ex_pred_taken) ||
                        (ex_taken && (ex_target != ex_pred_target)));
  assign flush       = mispredict;

  always_comb begin
    // NOTE: a default assignment first keeps this purely combinational; a path
    // that leaves next_pc unassigned would infer a latch.
    next_pc = pc_plus4;
    if (mispredict) begin
      next_pc = ex_taken ? ex_target : ex_pc_plus4;
    end else if (pred_taken) begin
      next_pc = pred_target;
    end
  end

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    else       return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
  endfunction

  // Control state of the table: valid bits and direction counters.
  // Writes land on the clock edge, so a same-cycle lookup of the same index
  // still sees the old contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // reader in this cycle sees the pre-edge value.
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (ex_valid) begin
      if (ex_hit) begin
        ctr_q[ex_idx] <= ctr_next(ctr_q[ex_idx], ex_taken);
      end else if (ex_taken) begin
        valid_q[ex_idx] <= 1'b1;
        ctr_q[ex_idx]   <= 2'b10;
      end
    end
  end

  // NOTE: tag and target arrays are deliberately not reset; they are only
  // observed behind a set valid bit, and leaving them reset-free lets them map
  // onto plain storage.
  // A taken resolution either refreshes a hit entry's target (tag unchanged)
  // or allocates over whatever sat at that index.
  always_ff @(posedge clk) begin
    if (ex_valid && ex_taken) begin
      tag_q[ex_idx]    <= ex_tag;
      target_q[ex_idx] <= ex_target;
    end
  end

  // Performance counters saturate rather than wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (ex_valid && (branch_cnt != '1)) begin
        branch_cnt <= branch_cnt + 32'd1;
      end
      if (mispredict && (mispredict_cnt != '1)) begin
        mispredict_cnt <= mispredict_cnt + 32'd1;
      end
    end
  end

  // Address bits outside the index/tag fields do not take part in the lookup.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_current[63:TAG_HI+1], pc_current[1:0],
                            ex_pc[63:TAG_HI+1], ex_pc[1:0]};

endmodule
